// File: rtl/idli_sx_m.sv
// -----------------------------------------------------------------------------
// idli_sx_m -- bit-serial execution unit
//
// Accepts one ALU op (ADD/AND/OR/XOR, optional rhs inversion) with full-width
// operands. It computes the op SLICE_W bits per cycle, LSB first, and ripples
// the carry between slices. It returns the result word plus {Z,N,C,V}.
// Latency is NSL = DATA_W/SLICE_W cycles from accept to o_sx_vld.
//
// Optional feature macro: IDLI_SX_CARRY_CHAIN_EN
//   defined   : C of each consumed op is saved; i_sx_cin_sel=1 at accept uses
//               the saved carry instead of i_sx_cin (multiword ADD/SUB).
//   undefined : no saved carry; i_sx_cin_sel is ignored.
//
// Ports
//   i_sx_gck      clock
//   i_sx_rst_n    async active-low reset
//   i_sx_vld      op request valid
//   o_sx_rdy      op accepted when i_sx_vld & o_sx_rdy
//   i_sx_op       0 ADD, 1 AND, 2 OR, 3 XOR
//   i_sx_inv      invert rhs before op
//   i_sx_cin      carry-in for ADD
//   i_sx_cin_sel  use saved carry as carry-in (carry-chain build only)
//   i_sx_lhs      lhs operand
//   i_sx_rhs      rhs operand
//   i_sx_flush    drop in-flight op, block new requests
//   o_sx_vld      result valid, held until i_sx_rdy
//   i_sx_rdy      consumer ready
//   o_sx_res      result word
//   o_sx_flags    {Z,N,C,V}
// -----------------------------------------------------------------------------
module idli_sx_m #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic              i_sx_gck,
    input  logic              i_sx_rst_n,
    input  logic              i_sx_vld,
    output logic              o_sx_rdy,
    input  logic [1:0]        i_sx_op,
    input  logic              i_sx_inv,
    input  logic              i_sx_cin,
    input  logic              i_sx_cin_sel,
    input  logic [DATA_W-1:0] i_sx_lhs,
    input  logic [DATA_W-1:0] i_sx_rhs,
    input  logic              i_sx_flush,
    output logic              o_sx_vld,
    input  logic              i_sx_rdy,
    output logic [DATA_W-1:0] o_sx_res,
    output logic [3:0]        o_sx_flags
);

    localparam int NSL   = DATA_W / SLICE_W;
    localparam int CTR_W = (NSL > 1) ? $clog2(NSL) : 1;

    if (SLICE_W < 1 || SLICE_W > DATA_W || (DATA_W % SLICE_W) != 0) begin : g_bad_cfg
        $error("idli_sx_m: SLICE_W must divide DATA_W and lie in 1..DATA_W");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_AND, OP_OR, OP_XOR} op_e;

    state_e              state_q, state_d;
    op_e                 op_q;
    logic                inv_q;
    logic [DATA_W-1:0]   lhs_q, rhs_q, res_q;
    logic [CTR_W-1:0]    ctr_q;
    logic                carry_q;
    logic                z_q;
    logic [3:0]          flags_q;

    logic                accept, consume, cin_eff, last, is_add;
    logic [SLICE_W-1:0]  sl_a, sl_b, sl_res;
    logic [SLICE_W:0]    sl_sum;
    logic                sl_cout, sl_c_msb, z_next;
    logic [DATA_W+SLICE_W-1:0] res_cat;

    // Flush wins over everything: it blocks new requests and a pending consume.
    assign o_sx_rdy = !i_sx_flush &&
                      (state_q == ST_IDLE || (state_q == ST_DONE && i_sx_rdy));
    assign accept   = i_sx_vld && o_sx_rdy;
    assign consume  = (state_q == ST_DONE) && i_sx_rdy && !i_sx_flush;
    assign last     = (ctr_q == CTR_W'(NSL - 1));
    assign is_add   = (op_q == OP_ADD);

`ifdef IDLI_SX_CARRY_CHAIN_EN
    logic saved_c_q, saved_c_fwd;
    // The op being consumed on this edge has not landed in saved_c_q yet, so a
    // back-to-back accept reads its C directly.
    assign saved_c_fwd = consume ? flags_q[1] : saved_c_q;
    assign cin_eff     = i_sx_cin_sel ? saved_c_fwd : i_sx_cin;

    always_ff @(posedge i_sx_gck or negedge i_sx_rst_n) begin
        if (!i_sx_rst_n)  saved_c_q <= 1'b0;
        else if (consume) saved_c_q <= flags_q[1];
    end
`else
    logic unused_cin_sel;
    assign unused_cin_sel = i_sx_cin_sel;
    assign cin_eff        = i_sx_cin;
`endif

    // Current slice: the low SLICE_W bits of the operand shift registers.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sl_a     = lhs_q[SLICE_W-1:0];
        sl_b     = rhs_q[SLICE_W-1:0] ^ {SLICE_W{inv_q}};
        sl_sum   = {1'b0, sl_a} + {1'b0, sl_b} + {{SLICE_W{1'b0}}, carry_q};
        sl_cout  = sl_sum[SLICE_W];
        // Carry into the slice MSB recovered from the sum bit: a ^ b ^ s.
        sl_c_msb = sl_a[SLICE_W-1] ^ sl_b[SLICE_W-1] ^ sl_sum[SLICE_W-1];
        sl_res   = sl_sum[SLICE_W-1:0];
        unique case (op_q)
            OP_AND:  sl_res = sl_a & sl_b;
            OP_OR:   sl_res = sl_a | sl_b;
            OP_XOR:  sl_res = sl_a ^ sl_b;
            default: sl_res = sl_sum[SLICE_W-1:0];
        endcase
        z_next  = z_q && (sl_res == '0);
        // Shift the new slice in at the MSB end; after NSL slices the word is aligned.
        res_cat = {sl_res, res_q};
    end

    always_ff @(posedge i_sx_gck or negedge i_sx_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (!i_sx_rst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN: begin
                if (i_sx_flush) state_d = ST_IDLE;
                else if (last)  state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_sx_flush)    state_d = ST_IDLE;
                else if (i_sx_rdy) state_d = accept ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sx_gck or negedge i_sx_rst_n) begin
        if (!i_sx_rst_n) begin
            // NOTE: operand shift registers are reset as well; they are a few flops, not an array,
            // and resetting them keeps X out of the serial datapath.
            op_q    <= OP_ADD;
            inv_q   <= 1'b0;
            lhs_q   <= '0;
            rhs_q   <= '0;
            res_q   <= '0;
            ctr_q   <= '0;
            carry_q <= 1'b0;
            z_q     <= 1'b0;
            flags_q <= '0;
        end else if (accept) begin
            op_q    <= op_e'(i_sx_op);
            inv_q   <= i_sx_inv;
            lhs_q   <= i_sx_lhs;
            rhs_q   <= i_sx_rhs;
            ctr_q   <= '0;
            carry_q <= cin_eff;
            z_q     <= 1'b1;
        end else if (state_q == ST_RUN && !i_sx_flush) begin
            lhs_q <= lhs_q >> SLICE_W;
            rhs_q <= rhs_q >> SLICE_W;
            res_q <= res_cat[DATA_W+SLICE_W-1:SLICE_W];
            ctr_q <= ctr_q + CTR_W'(1);
            z_q   <= z_next;
            // Logic ops leave the ripple carry alone.
            if (is_add) carry_q <= sl_cout;
            if (last) begin
                flags_q <= {z_next, sl_res[SLICE_W-1], is_add && sl_cout,
                            is_add && (sl_c_msb ^ sl_cout)};
            end
        end
    end

    assign o_sx_vld   = (state_q == ST_DONE);
    assign o_sx_res   = res_q;
    assign o_sx_flags = flags_q;

endmodule

// File: tb/tb_idli_sx_m.sv
// -----------------------------------------------------------------------------
// tb_idli_sx_m -- directed + random bench for idli_sx_m.
// Each accepted op pushes a full-width reference result into a scoreboard.
// Each produced result pops the scoreboard and is compared against it.
// -----------------------------------------------------------------------------
module tb_idli_sx_m;

    localparam int DATA_W = 16;
    parameter  int SLICE_W = 4;
    localparam int NSL = DATA_W / SLICE_W;
    localparam int FL_SL = (NSL > 2) ? 2 : NSL - 1;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        string       tag;
    } exp_t;

    logic        gck = 1'b0;
    logic        rst_n;
    logic        vld, rdy_o, inv, cin, cin_sel, flush, vld_o, cons_rdy;
    logic [1:0]  op;
    logic [15:0] lhs, rhs, res;
    logic [3:0]  flags;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic saved_c_m = 1'b0;

    idli_sx_m #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
        .i_sx_gck     (gck),
        .i_sx_rst_n   (rst_n),
        .i_sx_vld     (vld),
        .o_sx_rdy     (rdy_o),
        .i_sx_op      (op),
        .i_sx_inv     (inv),
        .i_sx_cin     (cin),
        .i_sx_cin_sel (cin_sel),
        .i_sx_lhs     (lhs),
        .i_sx_rhs     (rhs),
        .i_sx_flush   (flush),
        .o_sx_vld     (vld_o),
        .i_sx_rdy     (cons_rdy),
        .o_sx_res     (res),
        .o_sx_flags   (flags)
    );

    always #5 gck = ~gck;

    task automatic tick();
        @(posedge gck);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: ADD with overflow from operand/result signs.
    function automatic exp_t model(input logic [1:0] m_op, input logic m_inv, input logic m_cin,
                                   input logic [15:0] a, input logic [15:0] b, input string tag);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] s;
        logic        c, v;
        bb = b ^ {16{m_inv}};
        c  = 1'b0;
        v  = 1'b0;
        case (m_op)
            2'd0: begin
                s     = {1'b0, a} + {1'b0, bb} + 17'(m_cin);
                e.res = s[15:0];
                c     = s[16];
                v     = (a[15] == bb[15]) && (e.res[15] != a[15]);
            end
            2'd1:    e.res = a & bb;
            2'd2:    e.res = a | bb;
            default: e.res = a ^ bb;
        endcase
        e.flags = {(e.res == 16'h0), e.res[15], c, v};
        e.tag   = tag;
        return e;
    endfunction

    // Present a request, wait (bounded) for o_sx_rdy, and return just after the accept edge.
    task automatic send(input string tag, input logic [1:0] s_op, input logic s_inv, input logic s_cin,
                        input logic s_sel, input logic [15:0] a, input logic [15:0] b);
        logic cin_m;
        vld = 1'b1; op = s_op; inv = s_inv; cin = s_cin; cin_sel = s_sel; lhs = a; rhs = b;
        for (int i = 0; i < 100 && !rdy_o; i++) tick();
        check({tag, "_rdy"}, 32'(rdy_o), 32'd1);
`ifdef IDLI_SX_CARRY_CHAIN_EN
        cin_m = s_sel ? saved_c_m : s_cin;
`else
        cin_m = s_cin;
`endif
        sb.push_back(model(s_op, s_inv, cin_m, a, b, tag));
        tick();
        vld = 1'b0; cin_sel = 1'b0;
    endtask

    // Wait for o_sx_vld, check latency from accept, compare against the scoreboard head.
    task automatic wait_result();
        int   cnt = 0;
        exp_t e;
        while (!vld_o && cnt < 200) begin
            tick();
            cnt++;
        end
        check("latency", 32'(cnt), 32'(NSL));
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_vld"}, 32'(vld_o), 32'd1);
            check({e.tag, "_res"}, 32'(res), 32'(e.res));
            check({e.tag, "_flags"}, 32'(flags), 32'(e.flags));
            saved_c_m = e.flags[1];
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] s_op, input logic s_inv, input logic s_cin,
                         input logic s_sel, input logic [15:0] a, input logic [15:0] b);
        send(tag, s_op, s_inv, s_cin, s_sel, a, b);
        wait_result();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; op = 2'd0; inv = 1'b0; cin = 1'b0; cin_sel = 1'b0;
        lhs = '0; rhs = '0; flush = 1'b0; cons_rdy = 1'b1;
        #12;
        check("rst_vld", 32'(vld_o), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_rdy", 32'(rdy_o), 32'd1);
        rst_n = 1'b1;
        tick();

        // Directed arithmetic vectors.
        do_op("add_ff_1",   2'd0, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0001);
        do_op("sub_8000_1", 2'd0, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h0001);
        do_op("add_wrap",   2'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        do_op("and",        2'd1, 1'b0, 1'b0, 1'b0, 16'hF0F0, 16'h3C3C);
        do_op("or_inv",     2'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h7FFF);

        // Consumer stalls for 3 cycles: result and valid must hold.
        cons_rdy = 1'b0;
        send("xor_hold", 2'd3, 1'b0, 1'b0, 1'b0, 16'hA5A5, 16'hA5A5);
        wait_result();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_vld", 32'(vld_o), 32'd1);
            check("hold_res", 32'(res), 32'h0);
            check("hold_flags", 32'(flags), 32'h8);
        end
        cons_rdy = 1'b1;
        tick();
        check("hold_release_vld", 32'(vld_o), 32'd0);

        // Back-to-back: the next op is accepted on the consume edge, so latency stays NSL.
        send("b2b_a", 2'd0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1111);
        wait_result();
        check("b2b_rdy_in_done", 32'(rdy_o), 32'd1);
        send("b2b_b", 2'd0, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h0001);
        check("b2b_b_running", 32'(vld_o), 32'd0);
        wait_result();
        send("b2b_c", 2'd3, 1'b0, 1'b0, 1'b0, 16'h1357, 16'h2468);
        // Flush mid-RUN, with a competing request that must not be taken.
        for (int i = 0; i < FL_SL; i++) tick();
        flush = 1'b1; vld = 1'b1;
        check("flush_rdy", 32'(rdy_o), 32'd0);
        tick();
        flush = 1'b0; vld = 1'b0;
        void'(sb.pop_back());
        for (int i = 0; i < NSL + 2; i++) begin
            check("flush_no_vld", 32'(vld_o), 32'd0);
            tick();
        end

        // Multiword carry: C of the consumed op feeds the next op when cin_sel is set.
        do_op("chain_lo", 2'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        do_op("chain_hi", 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
`ifdef IDLI_SX_CARRY_CHAIN_EN
        check("chain_hi_word", 32'(res), 32'h0001);
`else
        check("chain_hi_word", 32'(res), 32'h0000);
`endif

        // Random ops against the reference model.
        for (int i = 0; i < 24; i++) begin
            do_op("rnd", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom));
        end

        // Make sure saved carry is 1 (carry-chain build) before the reset test.
        do_op("pre_rst", 2'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        do_op("pre_rst_f", 2'd0, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h0001);

        // Async reset mid-RUN: everything returns to reset values immediately.
        send("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
        rst_n = 1'b0;
        #1;
        check("rstmid_vld", 32'(vld_o), 32'd0);
        check("rstmid_res", 32'(res), 32'd0);
        check("rstmid_flags", 32'(flags), 32'd0);
        check("rstmid_rdy", 32'(rdy_o), 32'd1);
        sb.delete();
        saved_c_m = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        // Saved carry is cleared by reset, so a chained op sees carry-in 0.
        do_op("post_rst", 2'd0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
